serial_frame_receiver: RTL and testbench

- Far end of the ChessTimer serial display link: receives the bit stream and command strobes emitted by the display-side serializer and rebuilds DATA_W-bit words.
- Drives ldcReady back to the serializer as flow control.
- Presents each completed word to the display controller through a one-entry holding register with a valid/ack handshake.
- Flags malformed frames, overruns and stalled transfers.

---
 rtl/chess_link_pkg.sv | 33 +++
 rtl/link_strobe_detect.sv | 29 ++
 rtl/serial_frame_receiver.sv | 227 ++++++++++++++++++++++
 tb/tb_serial_frame_receiver.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chess_link_pkg
//  Description : Shared definitions for the ChessTimer serial display link.
//                Both the display-side serializer and the receiver import
//                this package so command encodings and frame width agree.
//  Revision    : 1.0 - initial release
// ============================================================================
package chess_link_pkg;

   // Link command encodings carried on OPER
   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_SHIFT = 2'b01;
   localparam logic [1:0] OP_LATCH = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   // Default payload width of one display frame
   localparam int DEF_DATA_W = 24;

   // Receiver frame-assembly states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_ABORT = 2'd2
   } rx_state_t;

   // Width of a counter that must hold values 0..n inclusive
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage : chess_link_pkg
`default_nettype wire

// File: rtl/link_strobe_detect.sv
`default_nettype none
// ============================================================================
//  Module      : link_strobe_detect
//  Description : Rising-edge detector for the link command enable. Emits a
//                single-cycle strobe so a held ENB executes one command only.
//  Revision    : 1.0 - initial release
// ============================================================================
module link_strobe_detect (
   input  logic clk,
   input  logic rst,
   input  logic enb,
   output logic stb
);

   logic r_enb_prev;

   // Remember last cycle's ENB level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_enb_prev <= 1'b0;
      end else begin
         r_enb_prev <= enb;
      end
   end

   assign stb = enb & ~r_enb_prev;

endmodule : link_strobe_detect
`default_nettype wire

// File: rtl/serial_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_receiver
//  Description : Receiving end of the ChessTimer serial display link. Shifts
//                in MSB-first frames, hands completed words to the display
//                controller through a one-entry valid/ack holding register,
//                and flags malformed frames, overruns and stalled transfers.
//                Optional build macro SERIAL_RX_PARITY_EN appends one even
//                parity bit to every frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_receiver
   import chess_link_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sData,
   input  logic [1:0]        OPER,
   input  logic              ENB,
   input  logic              linkRst,
   input  logic              dAck,
   input  logic              errClr,
   output logic [DATA_W-1:0] dataOut,
   output logic              dValid,
   output logic              ldcReady,
   output logic              frameErr,
   output logic              overrun
);

`ifdef SERIAL_RX_PARITY_EN
   localparam int FRAME_LEN = DATA_W + 1;
`else
   localparam int FRAME_LEN = DATA_W;
`endif
   localparam int CNT_W = cnt_width(FRAME_LEN);
   localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   rx_state_t             r_state;
   rx_state_t             w_state_nxt;
   logic [FRAME_LEN-1:0]  r_shreg;
   logic [FRAME_LEN-1:0]  w_shreg_nxt;
   logic [CNT_W-1:0]      r_bitcnt;
   logic [CNT_W-1:0]      w_bitcnt_nxt;
   logic [DATA_W-1:0]     r_dout;
   logic [DATA_W-1:0]     w_dout_nxt;
   logic                  r_dvalid;
   logic                  w_dvalid_nxt;
   logic                  r_ferr;
   logic                  r_ovr;
   logic                  w_ferr_set;
   logic                  w_ovr_set;
   logic                  w_stb;
   logic                  w_full;
   logic                  w_par_ok;
   logic                  w_timeout;
   logic [DATA_W-1:0]     w_payload;

   link_strobe_detect u_strobe (
      .clk (clk),
      .rst (rst),
      .enb (ENB),
      .stb (w_stb)
   );

   assign w_full    = (r_bitcnt == CNT_W'(FRAME_LEN));
   // Payload sits in the top DATA_W bits; a parity bit, if any, arrives last
   assign w_payload = r_shreg[FRAME_LEN-1 -: DATA_W];

`ifdef SERIAL_RX_PARITY_EN
   assign w_par_ok  = ~(^r_shreg);
`else
   assign w_par_ok  = 1'b1;
`endif

   generate
      if (TIMEOUT_CYC > 0) begin : g_timeout
         logic [TO_W-1:0] r_tocnt;

         // Count idle cycles since the last command while a frame is open
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_tocnt <= '0;
            end else if (r_state != ST_RECV || w_stb || linkRst) begin
               r_tocnt <= '0;
            end else if (!w_timeout) begin
               r_tocnt <= r_tocnt + TO_W'(1);
            end
         end

         assign w_timeout = (r_state == ST_RECV) &&
                            (r_tocnt == TO_W'(TIMEOUT_CYC - 1));
      end else begin : g_no_timeout
         assign w_timeout = 1'b0;
      end
   endgenerate

   // Next-state, datapath and flag-event decode
   always_comb begin
      w_state_nxt  = r_state;
      w_shreg_nxt  = r_shreg;
      w_bitcnt_nxt = r_bitcnt;
      w_dout_nxt   = r_dout;
      w_dvalid_nxt = r_dvalid & ~dAck;
      w_ferr_set   = 1'b0;
      w_ovr_set    = 1'b0;

      if (linkRst) begin
         // Link reset beats any command strobe in the same cycle
         w_state_nxt  = ST_IDLE;
         w_shreg_nxt  = '0;
         w_bitcnt_nxt = '0;
         w_dvalid_nxt = 1'b0;
      end else begin
         case (r_state)
            ST_ABORT: begin
               w_state_nxt  = ST_IDLE;
               w_shreg_nxt  = '0;
               w_bitcnt_nxt = '0;
            end
            default: begin
               if (w_stb) begin
                  case (OPER)
                     OP_SHIFT: begin
                        if (w_full) begin
                           w_ferr_set   = 1'b1;
                           w_shreg_nxt  = '0;
                           w_bitcnt_nxt = '0;
                           w_state_nxt  = ST_ABORT;
                        end else begin
                           w_shreg_nxt  = {r_shreg[FRAME_LEN-2:0], sData};
                           w_bitcnt_nxt = r_bitcnt + CNT_W'(1);
                           w_state_nxt  = ST_RECV;
                        end
                     end
                     OP_LATCH: begin
                        if (!w_full || !w_par_ok) begin
                           w_ferr_set = 1'b1;
                        end else if (!r_dvalid || dAck) begin
                           w_dout_nxt   = w_payload;
                           w_dvalid_nxt = 1'b1;
                        end else begin
                           w_ovr_set = 1'b1;
                        end
                        w_shreg_nxt  = '0;
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = ST_IDLE;
                     end
                     OP_CLEAR: begin
                        w_shreg_nxt  = '0;
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = ST_IDLE;
                     end
                     default: begin
                     end
                  endcase
               end else if (r_state == ST_RECV && w_timeout) begin
                  w_ferr_set   = 1'b1;
                  w_shreg_nxt  = '0;
                  w_bitcnt_nxt = '0;
                  w_state_nxt  = ST_ABORT;
               end
            end
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Shift register and bit counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shreg  <= '0;
         r_bitcnt <= '0;
      end else begin
         r_shreg  <= w_shreg_nxt;
         r_bitcnt <= w_bitcnt_nxt;
      end
   end

   // One-entry holding register towards the display controller
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout   <= '0;
         r_dvalid <= 1'b0;
      end else begin
         r_dout   <= w_dout_nxt;
         r_dvalid <= w_dvalid_nxt;
      end
   end

   // Sticky error flags; a new error outranks a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ferr <= 1'b0;
         r_ovr  <= 1'b0;
      end else begin
         if (w_ferr_set) begin
            r_ferr <= 1'b1;
         end else if (errClr) begin
            r_ferr <= 1'b0;
         end
         if (w_ovr_set) begin
            r_ovr <= 1'b1;
         end else if (errClr) begin
            r_ovr <= 1'b0;
         end
      end
   end

   assign dataOut  = r_dout;
   assign dValid   = r_dvalid;
   assign ldcReady = ~r_dvalid;
   assign frameErr = r_ferr;
   assign overrun  = r_ovr;

endmodule : serial_frame_receiver
`default_nettype wire

// File: tb/tb_serial_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_frame_receiver
//  Description : Self-checking bench for serial_frame_receiver. A transaction
//                level model (bit queue plus holding-register variables)
//                predicts every output after each link operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_receiver;
   import chess_link_pkg::*;

   localparam int DW = 24;
   localparam int TO = 16;
`ifdef SERIAL_RX_PARITY_EN
   localparam int FL = DW + 1;
`else
   localparam int FL = DW;
`endif

   logic          clk;
   logic          rst;
   logic          sData;
   logic [1:0]    OPER;
   logic          ENB;
   logic          linkRst;
   logic          dAck;
   logic          errClr;
   logic [DW-1:0] dataOut;
   logic          dValid;
   logic          ldcReady;
   logic          frameErr;
   logic          overrun;

   // Reference model state
   bit            mq[$];
   logic [DW-1:0] mdout;
   bit            mdv;
   bit            mfe;
   bit            mov;

   int n_total;
   int n_pass;

   serial_frame_receiver #(
      .DATA_W      (DW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sData    (sData),
      .OPER     (OPER),
      .ENB      (ENB),
      .linkRst  (linkRst),
      .dAck     (dAck),
      .errClr   (errClr),
      .dataOut  (dataOut),
      .dValid   (dValid),
      .ldcReady (ldcReady),
      .frameErr (frameErr),
      .overrun  (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".dValid"},   dValid,       mdv);
      check({tag, ".ldcReady"}, ldcReady,     !mdv);
      check({tag, ".dataOut"},  dataOut,      mdout);
      check({tag, ".frameErr"}, frameErr,     mfe);
      check({tag, ".overrun"},  overrun,      mov);
      check({tag, ".bitCnt"},   dut.r_bitcnt, mq.size());
   endtask

   function automatic logic [DW-1:0] model_payload();
      logic [DW-1:0] p = '0;
      for (int i = 0; i < DW; i++) p = {p[DW-2:0], mq[i]};
      return p;
   endfunction

   function automatic bit model_parity_ok();
`ifdef SERIAL_RX_PARITY_EN
      return (^model_payload()) == mq[DW];
`else
      return 1'b1;
`endif
   endfunction

   function automatic void model_reset();
      mq.delete();
      mdout = '0;
      mdv = 0; mfe = 0; mov = 0;
   endfunction

   // Frame-level rules: one command with optional dAck/errClr in its cycle
   function automatic void model_cmd(input logic [1:0] op, input bit b, input bit ack, input bit clr);
      bit ack_eff = ack && mdv;
      bit loaded = 0;
      if (clr) begin mfe = 0; mov = 0; end
      case (op)
         OP_SHIFT: begin
            if (mq.size() == FL) begin mfe = 1; mq.delete(); end
            else mq.push_back(b);
         end
         OP_LATCH: begin
            if (mq.size() != FL || !model_parity_ok()) mfe = 1;
            else if (!mdv || ack) begin mdout = model_payload(); loaded = 1; end
            else mov = 1;
            mq.delete();
         end
         OP_CLEAR: mq.delete();
         default: ;
      endcase
      if (loaded) mdv = 1;
      else if (ack_eff) mdv = 0;
   endfunction

   task automatic cmd(input logic [1:0] op, input bit b, input bit ack, input bit clr);
      @(negedge clk);
      ENB = 1'b1; OPER = op; sData = b; dAck = ack; errClr = clr;
      @(negedge clk);
      ENB = 1'b0; OPER = OP_NOP; sData = 1'($urandom); dAck = 1'b0; errClr = 1'b0;
      model_cmd(op, b, ack, clr);
      check_all("cmd");
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      // n idle negedges after a command leave n+1 command-free edges
      if (mq.size() > 0 && n + 1 >= TO) begin mfe = 1; mq.delete(); end
   endtask

   task automatic ack_only();
      @(negedge clk); dAck = 1'b1;
      @(negedge clk); dAck = 1'b0;
      mdv = 0;
      check_all("ack");
   endtask

   task automatic errclr_only();
      @(negedge clk); errClr = 1'b1;
      @(negedge clk); errClr = 1'b0;
      mfe = 0; mov = 0;
      check_all("errclr");
   endtask

   // linkRst together with a SHIFT strobe: the link reset must win
   task automatic link_rst();
      @(negedge clk); linkRst = 1'b1; ENB = 1'b1; OPER = OP_SHIFT; sData = 1'b1;
      @(negedge clk); linkRst = 1'b0; ENB = 1'b0; OPER = OP_NOP;
      mq.delete(); mdv = 0;
      check_all("linkrst");
   endtask

   task automatic held_shift(input bit b);
      @(negedge clk); ENB = 1'b1; OPER = OP_SHIFT; sData = b;
      repeat (5) @(negedge clk);
      ENB = 1'b0; OPER = OP_NOP;
      model_cmd(OP_SHIFT, b, 0, 0);
      check_all("held");
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input bit ack);
      for (int i = DW - 1; i >= 0; i--) cmd(OP_SHIFT, d[i], 0, 0);
`ifdef SERIAL_RX_PARITY_EN
      cmd(OP_SHIFT, ^d, 0, 0);
`endif
      cmd(OP_LATCH, 0, ack, 0);
   endtask

   task automatic shifts(input int n);
      for (int i = 0; i < n; i++) cmd(OP_SHIFT, 1'($urandom), 0, 0);
   endtask

   initial begin
      n_total = 0; n_pass = 0;
      rst = 1'b1; sData = 1'b0; OPER = OP_NOP; ENB = 1'b0;
      linkRst = 1'b0; dAck = 1'b0; errClr = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_all("reset");

      // Normal frame and latency/handshake
      send_frame(24'hA5C3F0, 0);
      check("frame.word", dataOut, 24'hA5C3F0);
      ack_only();

      // Held ENB executes one SHIFT only
      held_shift(1'b1);
      check("held.cnt", dut.r_bitcnt, 1);
      cmd(OP_CLEAR, 0, 0, 0);

      // Short frame
      shifts(FL - 1);
      cmd(OP_LATCH, 0, 0, 0);
      check("short.ferr", frameErr, 1'b1);
      errclr_only();

      // Overrun, then latch with coincident dAck
      send_frame(24'h000001, 0);
      send_frame(24'hFFFFFF, 0);
      check("ovr.flag", overrun, 1'b1);
      check("ovr.keep", dataOut, 24'h000001);
      errclr_only();
      send_frame(24'hFFFFFF, 1);
      check("ovr.ackword", dataOut, 24'hFFFFFF);
      check("ovr.noflag", overrun, 1'b0);

      // linkRst mid-frame with a full holding register
      shifts(5);
      link_rst();
      check("lrst.dv", dValid, 1'b0);

      // Bit overflow, then errClr coinciding with an error event
      shifts(FL + 1);
      check("ovf.ferr", frameErr, 1'b1);
      errclr_only();
      cmd(OP_LATCH, 0, 0, 1);
      check("clrset.ferr", frameErr, 1'b1);
      errclr_only();

      // Timeout abort
      shifts(10);
      idle(20);
      check_all("timeout");
      check("timeout.state", dut.r_state, ST_IDLE);
      errclr_only();

      // Randomized frames of varying length with random handshakes
      for (int f = 0; f < 30; f++) begin
         logic [DW-1:0] d = DW'($urandom);
         int r = $urandom_range(0, 9);
         int len = (r == 0) ? FL - 1 - $urandom_range(0, 3) :
                   (r == 1) ? FL + 1 : FL;
         for (int i = 0; i < len; i++) begin
            bit b = (i < DW) ? d[DW-1-i] : ((i == DW) ? ^d : 1'($urandom));
            if ($urandom_range(0, 9) == 0) begin
               idle($urandom_range(0, 3));
               check_all("rnd.gap");
            end
            if ($urandom_range(0, 19) == 0) cmd(OP_NOP, b, 0, 0);
            cmd(OP_SHIFT, b, 0, 0);
         end
         cmd(OP_LATCH, 0, 1'($urandom), 1'($urandom_range(0, 4) == 0));
         if ($urandom_range(0, 1) == 1) ack_only();
         if ($urandom_range(0, 3) == 0) errclr_only();
      end

      // Asynchronous reset between edges while a frame is open
      send_frame(24'h5A5A5A, 0);
      shifts(3);
      cmd(OP_LATCH, 0, 0, 0);
      shifts(4);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("arst");
      @(negedge clk);
      rst = 1'b0;
      send_frame(24'h13579B, 0);
      check("postrst.word", dataOut, 24'h13579B);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_serial_frame_receiver
`default_nettype wire
